// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one fixed-latency memory port.
// Define ARB_RR_EN for round-robin arbitration; the default is LS-priority with a fetch starvation limit.
module mem_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [10:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        ls_req_valid,
   input  logic        ls_req_we,
   input  logic [10:0] ls_req_addr,
   input  logic [63:0] ls_req_wdata,
   input  logic [3:0]  ls_req_len,
   output logic        ls_req_ready,
   output logic        ls_resp_valid,
   output logic [63:0] ls_resp_data,
   output logic        mem_en,
   output logic        mem_we,
   output logic [10:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [3:0]  mem_len,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   // state | meaning
   // IDLE  | ready to the arbitration winner, accept one request
   // ISSUE | one-cycle mem_en with the latched request
   // WAIT  | read latency countdown, rdata captured on the final cycle
   // RESP  | one-cycle resp_valid pulse to the owner
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic        grant_if, grant_ls, accept;
   logic        own_ls_q, we_q;
   logic [10:0] addr_q;
   logic [63:0] wdata_q;
   logic [3:0]  len_q;
   logic [2:0]  wait_cnt;
   logic [31:0] if_data_q;
   logic [63:0] ls_data_q;

`ifdef ARB_RR_EN
   logic last_ls;

   assign grant_if = if_req_valid && (!ls_req_valid || last_ls);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        last_ls <= 1'b0;
      else if (accept) last_ls <= grant_ls;
   end
`else
   logic [3:0] starve_cnt;
   logic       starve_hit;

   assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
   assign grant_if   = if_req_valid && (!ls_req_valid || starve_hit);

   // Only counts LS wins that actually kept a waiting fetch out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= 4'd0;
      end else if (state == IDLE) begin
         if (grant_if || !if_req_valid) starve_cnt <= 4'd0;
         else if (grant_ls)              starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   assign grant_ls = ls_req_valid && !grant_if;
   assign accept   = (state == IDLE) && (grant_if || grant_ls);
   assign busy     = (state != IDLE);
   assign if_resp_data = if_data_q;
   assign ls_resp_data = ls_data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = 11'd0;
      mem_wdata     = 64'd0;
      mem_len       = 4'd0;
      case (state)
         IDLE: begin
            if_req_ready = grant_if;
            ls_req_ready = grant_ls;
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_len   = len_q;
            state_nxt = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd0) state_nxt = RESP;
         end
         RESP: begin
            if_resp_valid = !own_ls_q;
            ls_resp_valid = own_ls_q;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         own_ls_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 11'd0;
         wdata_q   <= 64'd0;
         len_q     <= 4'd0;
         wait_cnt  <= 3'd0;
         if_data_q <= 32'd0;
         ls_data_q <= 64'd0;
      end else begin
         if (accept) begin
            own_ls_q <= grant_ls;
            if (grant_ls) begin
               we_q    <= ls_req_we;
               addr_q  <= ls_req_addr;
               wdata_q <= ls_req_wdata;
               len_q   <= ls_req_len;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= if_req_addr;
               wdata_q <= 64'd0;
               len_q   <= 4'd4;
            end
         end
         if (state == ISSUE)
            wait_cnt <= 3'(MEM_LAT - 1);
         else if (state == WAIT && wait_cnt != 3'd0)
            wait_cnt <= wait_cnt - 3'd1;
         if (state == ISSUE && we_q)
            ls_data_q <= 64'd0;
         if (state == WAIT && wait_cnt == 3'd0) begin
            if (own_ls_q) ls_data_q <= mem_rdata;
            else          if_data_q <= mem_rdata[31:0];
         end
      end
   end

endmodule
